// File: rtl/wfg_stim_sine_mc_wishbone_reg.sv
// Wishbone register block for a multi-channel sine stimulus: per-channel CTRL/INC/GAIN/OFFSET with
// shadowed commit. Define WFG_STIM_SINE_MC_ERR_EN to add wbs_err_o for unmapped / illegal accesses.
module wfg_stim_sine_mc_wishbone_reg #(
    parameter int BUSW = 32,
    parameter int NCH  = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [BUSW/8-1:0] wbs_sel_i,
    input  logic [BUSW-1:0]   wbs_dat_i,
    input  logic [BUSW-1:0]   wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [BUSW-1:0]   wbs_dat_o,
`ifdef WFG_STIM_SINE_MC_ERR_EN
    output logic              wbs_err_o,
`endif
    output logic [NCH-1:0]    ctrl_en_q_o,
    output logic [NCH*16-1:0] inc_val_q_o,
    output logic [NCH*16-1:0] gain_val_q_o,
    output logic [NCH*18-1:0] offset_val_q_o,
    output logic [NCH-1:0]    update_o
);
    localparam int AW = BUSW - 2;
    localparam logic [15:0] INC_RST  = 16'h1000;
    localparam logic [15:0] GAIN_RST = 16'h4000;

    logic [AW-1:0]   wadr;
    logic            is_ch, is_commit, is_status, mapped, accept, err_cond;
    logic            ack_q, err_q;
    logic [BUSW-1:0] dat_q, rd_data;
    logic [NCH-1:0]  hit, en_q, pending, update_q;
    logic [15:0]     inc_sh [NCH], gain_sh [NCH], inc_act [NCH], gain_act [NCH];
    logic [17:0]     off_sh [NCH], off_act [NCH];

    function automatic logic [BUSW-1:0] merge(input logic [BUSW-1:0] old,
                                              input logic [BUSW-1:0] d,
                                              input logic [BUSW/8-1:0] s);
        logic [BUSW-1:0] r;
        r = old;
        for (int b = 0; b < BUSW/8; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    assign wadr      = wbs_adr_i[BUSW-1:2];
    assign is_ch     = wadr < AW'(NCH*4);
    assign is_commit = wadr == AW'(NCH*4);
    assign is_status = wadr == AW'(NCH*4 + 1);
    assign mapped    = is_ch | is_commit | is_status;
    assign accept    = wbs_stb_i & wbs_cyc_i & ~ack_q & ~err_q;

`ifdef WFG_STIM_SINE_MC_ERR_EN
    assign err_cond  = ~mapped | (is_status & wbs_we_i);
    assign wbs_err_o = err_q & ~wb_rst_i;
`else
    assign err_cond  = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        hit     = '0;
        for (int c = 0; c < NCH; c++) begin
            hit[c] = is_ch && (wadr[4:2] == 3'(c));
            if (hit[c]) begin
                case (wadr[1:0])
                    2'd0:    rd_data = BUSW'(en_q[c]);
                    2'd1:    rd_data = BUSW'(inc_sh[c]);
                    2'd2:    rd_data = BUSW'(gain_sh[c]);
                    default: rd_data = BUSW'(off_sh[c]);
                endcase
            end
        end
        if (is_status) rd_data = BUSW'(pending);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= '0;
            pending  <= '0;
            update_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                inc_sh[c]  <= INC_RST;
                inc_act[c] <= INC_RST;
                gain_sh[c] <= GAIN_RST;
                gain_act[c] <= GAIN_RST;
                off_sh[c]  <= '0;
                off_act[c] <= '0;
            end
        end else begin
            ack_q    <= accept & ~err_cond;
            err_q    <= accept & err_cond;
            dat_q    <= (accept & ~wbs_we_i & ~err_cond) ? rd_data : '0;
            update_q <= '0;
            if (accept & wbs_we_i) begin
                for (int c = 0; c < NCH; c++) begin
                    if (hit[c]) begin
                        case (wadr[1:0])
                            2'd0: if (wbs_sel_i[0]) en_q[c] <= wbs_dat_i[0];
                            2'd1: inc_sh[c]  <= 16'(merge(BUSW'(inc_sh[c]), wbs_dat_i, wbs_sel_i));
                            2'd2: gain_sh[c] <= 16'(merge(BUSW'(gain_sh[c]), wbs_dat_i, wbs_sel_i));
                            default: off_sh[c] <= 18'(merge(BUSW'(off_sh[c]), wbs_dat_i, wbs_sel_i));
                        endcase
                        if (wadr[1:0] != 2'd0) pending[c] <= 1'b1;
                    end
                    // Commit only moves channels that actually have a pending shadow.
                    if (is_commit && wbs_sel_i[0] && wbs_dat_i[c] && pending[c]) begin
                        inc_act[c]  <= inc_sh[c];
                        gain_act[c] <= gain_sh[c];
                        off_act[c]  <= off_sh[c];
                        update_q[c] <= 1'b1;
                        pending[c]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Gate with reset so a transaction accepted just before reset is never acknowledged.
    assign wbs_ack_o   = ack_q & ~wb_rst_i;
    assign wbs_dat_o   = wbs_ack_o ? dat_q : '0;
    assign update_o    = update_q & {NCH{~wb_rst_i}};
    assign ctrl_en_q_o = en_q;

    always_comb begin
        inc_val_q_o    = '0;
        gain_val_q_o   = '0;
        offset_val_q_o = '0;
        for (int c = 0; c < NCH; c++) begin
            inc_val_q_o[c*16 +: 16]    = inc_act[c];
            gain_val_q_o[c*16 +: 16]   = gain_act[c];
            offset_val_q_o[c*18 +: 18] = off_act[c];
        end
    end
endmodule

// File: tb/tb_wfg_stim_sine_mc_wishbone_reg.sv
// Self-checking bench: directed scenarios plus randomized traffic against a register-map model.
module tb_wfg_stim_sine_mc_wishbone_reg;
    localparam int NCH = 4;
    localparam logic [31:0] COMMIT_A = NCH*16;
    localparam logic [31:0] STATUS_A = NCH*16 + 4;

    logic clk = 1'b0, rst = 1'b1, stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0] sel = '0;
    logic [31:0] dat_i = '0, adr = '0;
    logic ack;
    logic [31:0] dat_o;
    logic err_o;
    logic [NCH-1:0] en_o, upd_o;
    logic [NCH*16-1:0] inc_o, gain_o;
    logic [NCH*18-1:0] off_o;

    int total = 0, passed = 0;

    wfg_stim_sine_mc_wishbone_reg #(.BUSW(32), .NCH(NCH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
`ifdef WFG_STIM_SINE_MC_ERR_EN
        .wbs_err_o(err_o),
`endif
        .ctrl_en_q_o(en_o), .inc_val_q_o(inc_o), .gain_val_q_o(gain_o),
        .offset_val_q_o(off_o), .update_o(upd_o)
    );
`ifndef WFG_STIM_SINE_MC_ERR_EN
    assign err_o = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model: architectural register contents.
    logic           m_en [NCH];
    logic [15:0]    m_inc_sh [NCH], m_inc [NCH], m_gain_sh [NCH], m_gain [NCH];
    logic [17:0]    m_off_sh [NCH], m_off [NCH];
    logic [NCH-1:0] m_pend;

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [NCH*16-1:0] pk16(input logic [15:0] a [NCH]);
        logic [NCH*16-1:0] v = '0;
        for (int c = 0; c < NCH; c++) v[c*16 +: 16] = a[c];
        return v;
    endfunction

    function automatic logic [NCH*18-1:0] pk18(input logic [17:0] a [NCH]);
        logic [NCH*18-1:0] v = '0;
        for (int c = 0; c < NCH; c++) v[c*18 +: 18] = a[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] pk_en();
        logic [NCH-1:0] v = '0;
        for (int c = 0; c < NCH; c++) v[c] = m_en[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_inc_sh[c] = 16'h1000; m_inc[c] = 16'h1000;
            m_gain_sh[c] = 16'h4000; m_gain[c] = 16'h4000; m_off_sh[c] = 0; m_off[c] = 0;
        end
        m_pend = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1; stb = 0; cyc = 0; we = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    // One transaction; samples the cycle after acceptance.
    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic k, output logic [31:0] r, output logic [NCH-1:0] u, output logic e);
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s;
        @(posedge clk); #1;
        k = ack; r = dat_o; u = upd_o; e = err_o;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic test_reset();
        logic k, e; logic [31:0] r; logic [NCH-1:0] u;
        total++; if ({ack, dat_o, upd_o} !== '0) $display("FAIL reset_bus ack=%b dat=%h upd=%b exp 0", ack, dat_o, upd_o); else passed++;
        total++; if ({inc_o, gain_o, off_o, en_o} !== {pk16(m_inc), pk16(m_gain), pk18(m_off), pk_en()})
            $display("FAIL reset_outputs inc=%h gain=%h off=%h en=%b", inc_o, gain_o, off_o, en_o); else passed++;
        for (int c = 0; c < NCH; c++) begin
            bus(0, c*16 + 8, 0, 4'hF, k, r, u, e);
            total++; if (!k || r !== 32'h4000) $display("FAIL reset_gain ch%0d ack=%b got %h exp 00004000", c, k, r); else passed++;
            bus(0, c*16 + 4, 0, 4'hF, k, r, u, e);
            total++; if (!k || r !== 32'h1000 || u !== '0) $display("FAIL reset_inc ch%0d ack=%b got %h upd=%b exp 00001000", c, k, r, u); else passed++;
        end
        bus(0, STATUS_A, 0, 4'hF, k, r, u, e);
        total++; if (r !== 0) $display("FAIL reset_status got %h exp 0", r); else passed++;
    endtask

    task automatic test_commit();
        logic k, e; logic [31:0] r; logic [NCH-1:0] u;
        bus(1, 32'h14, 32'h2345, 4'hF, k, r, u, e);
        total++; if (inc_o[16 +: 16] !== 16'h1000) $display("FAIL commit_shadow_only got %h exp 1000", inc_o[16 +: 16]); else passed++;
        bus(0, STATUS_A, 0, 4'hF, k, r, u, e);
        total++; if (r !== 32'h2) $display("FAIL commit_status_pend got %h exp 2", r); else passed++;
        bus(1, COMMIT_A, 32'h2, 4'h1, k, r, u, e);
        total++; if (inc_o[16 +: 16] !== 16'h2345 || u !== 4'b0010) $display("FAIL commit_apply inc=%h upd=%b exp 2345/0010", inc_o[16 +: 16], u); else passed++;
        @(posedge clk); #1;
        total++; if (upd_o !== '0) $display("FAIL commit_pulse_len upd=%b exp 0", upd_o); else passed++;
        m_inc_sh[1] = 16'h2345; m_inc[1] = 16'h2345;
        bus(0, STATUS_A, 0, 4'hF, k, r, u, e);
        total++; if (r !== 0) $display("FAIL commit_status_clr got %h exp 0", r); else passed++;
    endtask

    task automatic test_byte_lanes();
        logic k, e; logic [31:0] r; logic [NCH-1:0] u;
        bus(1, 32'hC, 32'h3FFFF, 4'b0001, k, r, u, e);
        bus(0, 32'hC, 0, 4'hF, k, r, u, e);
        total++; if (r !== 32'h000FF) $display("FAIL lanes_partial got %h exp 000ff", r); else passed++;
        bus(1, 32'hC, 32'hFFFFFFFF, 4'hF, k, r, u, e);
        bus(0, 32'hC, 0, 4'hF, k, r, u, e);
        total++; if (r !== 32'h3FFFF) $display("FAIL lanes_full got %h exp 3ffff", r); else passed++;
        m_off_sh[0] = 18'h3FFFF; m_pend[0] = 1;
    endtask

    task automatic test_back_to_back();
        logic [5:0] acks;
        logic en_ok = 1;
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 1; adr = 32'h20; dat_i = 1; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            acks[i] = ack;
            if (i > 0 && en_o[2] !== 1'b1) en_ok = 0;
            if (i < 5) begin @(posedge clk); #1; end
        end
        stb = 0; cyc = 0; we = 0;
        m_en[2] = 1;
        total++; if (acks !== 6'b101010) $display("FAIL held_stb_acks got %b exp 101010 (cycle1 at lsb)", acks); else passed++;
        total++; if (!en_ok) $display("FAIL held_stb_en en=%b exp bit2 from T+1", en_o); else passed++;
    endtask

    task automatic test_unmapped();
        logic k, e; logic [31:0] r; logic [NCH-1:0] u;
        do_reset();
        bus(0, NCH*16 + 8, 0, 4'hF, k, r, u, e);
`ifdef WFG_STIM_SINE_MC_ERR_EN
        total++; if (k !== 0 || e !== 1 || r !== 0) $display("FAIL unmapped_read ack=%b err=%b dat=%h exp 0/1/0", k, e, r); else passed++;
`else
        total++; if (k !== 1 || r !== 0) $display("FAIL unmapped_read ack=%b dat=%h exp 1/0", k, r); else passed++;
`endif
        bus(1, COMMIT_A, 32'hFF, 4'hF, k, r, u, e);
        total++; if (u !== '0 || inc_o !== pk16(m_inc)) $display("FAIL commit_none upd=%b exp 0", u); else passed++;
    endtask

    task automatic test_reset_abort();
        logic k, e; logic [31:0] r; logic [NCH-1:0] u;
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = 1; adr = 32'h38; dat_i = 32'h1234; sel = 4'hF;
        @(posedge clk); #1;
        rst = 1; stb = 0; cyc = 0; we = 0;
        #1;
        total++; if (ack !== 0) $display("FAIL abort_ack ack=%b exp 0", ack); else passed++;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        bus(0, 32'h38, 0, 4'hF, k, r, u, e);
        total++; if (r !== 32'h4000) $display("FAIL abort_gain got %h exp 00004000", r); else passed++;
    endtask

    task automatic test_random();
        logic k, e, w, ek, ee; logic [31:0] r, a, d, er, v; logic [NCH-1:0] u, eu; logic [3:0] s;
        int kind, c, ri, bad = 0;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9); w = $urandom_range(0, 1); d = $urandom; s = 4'($urandom);
            c = $urandom_range(0, NCH-1); ri = $urandom_range(0, 3);
            er = 0; eu = 0; ee = 0;
            if (kind <= 5) begin
                a = c*16 + ri*4;
                if (w) begin
                    v = d & lane_mask(s);
                    case (ri)
                        0: if (s[0]) m_en[c] = d[0];
                        1: m_inc_sh[c]  = 16'((32'(m_inc_sh[c]) & ~lane_mask(s)) | v);
                        2: m_gain_sh[c] = 16'((32'(m_gain_sh[c]) & ~lane_mask(s)) | v);
                        default: m_off_sh[c] = 18'((32'(m_off_sh[c]) & ~lane_mask(s)) | v);
                    endcase
                    if (ri != 0) m_pend[c] = 1;
                end else begin
                    case (ri)
                        0: er = 32'(m_en[c]);
                        1: er = 32'(m_inc_sh[c]);
                        2: er = 32'(m_gain_sh[c]);
                        default: er = 32'(m_off_sh[c]);
                    endcase
                end
            end else if (kind <= 7) begin
                a = COMMIT_A; w = 1; d = 32'($urandom_range(0, 255));
                if (s[0])
                    for (int j = 0; j < NCH; j++)
                        if (d[j] && m_pend[j]) begin
                            m_inc[j] = m_inc_sh[j]; m_gain[j] = m_gain_sh[j]; m_off[j] = m_off_sh[j];
                            m_pend[j] = 0; eu[j] = 1;
                        end
            end else if (kind == 8) begin
                a = STATUS_A;
                if (!w) er = 32'(m_pend);
`ifdef WFG_STIM_SINE_MC_ERR_EN
                else ee = 1;
`endif
            end else begin
                a = NCH*16 + 8 + 4*$urandom_range(0, 40);
`ifdef WFG_STIM_SINE_MC_ERR_EN
                ee = 1;
`endif
            end
            a = a | 32'($urandom_range(0, 3));
            ek = !ee;
            bus(w, a, d, s, k, r, u, e);
            total++;
            if (k !== ek || e !== ee || r !== er || u !== eu || en_o !== pk_en() || inc_o !== pk16(m_inc)
                || gain_o !== pk16(m_gain) || off_o !== pk18(m_off)) begin
                if (bad < 10) $display("FAIL rand n=%0d we=%b adr=%h ack=%b err=%b dat=%h upd=%b exp ack=%b err=%b dat=%h upd=%b",
                                       n, w, a, k, e, r, u, ek, ee, er, eu);
                bad++;
            end else passed++;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_commit();
        test_byte_lanes();
        test_back_to_back();
        test_unmapped();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
